// File: rtl/instr_sequencer.sv
// Multi-cycle control sequencer for the 8-bit Harvard core: fetch, decode, exec/mem/writeback.
// Latency (zero-wait memories, fetch through last writeback): LDI/ST 3, MOV/UNA/ALU/LD 4, DUAL 5.
// Stalls in FETCH until imem_valid and in MEM until dmem_ready; HALT stops until reset.
`timescale 1ns/1ps
module instr_sequencer #(
  parameter int              PC_W   = 8,
  parameter logic [PC_W-1:0] RST_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     imem_data,
  input  logic            imem_valid,
  input  logic            dmem_ready,
  output logic [PC_W-1:0] pc,
  output logic            imem_req,
  output logic [31:0]     ir,
  output logic            alu_en,
  output logic            dmem_re,
  output logic            dmem_we,
  output logic            rf_we,
  output logic [1:0]      rf_wsel,
  output logic            rf_dsel,
  output logic            halted,
  output logic            illegal
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_WB2, S_HALT
  } state_t;

  state_t          state_q;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;
  logic [31:0]     ir_q;
  logic            illegal_q;
  logic [5:0]      opcode;

  // Opcode classes; these only matter once ir_q holds the instruction in flight.
  logic is_ldi, is_mov, is_ld, is_st, is_exec, is_dual, is_halt;

  assign opcode = ir_q[31:26];
  assign pc_d   = pc_q + PC_W'(1);

  // Classify the latched opcode into its sequencing class.
  always_comb begin
    is_ldi  = (opcode == 6'b000000);
    is_mov  = (opcode == 6'b000001);
    is_ld   = (opcode == 6'b000010);
    is_st   = (opcode == 6'b000011);
    // MOV plus the contiguous 000100..001111 block (ALU, UNA and DUAL) all need an ALU cycle.
    is_exec = is_mov || ((opcode >= 6'b000100) && (opcode <= 6'b001111));
    is_dual = (opcode == 6'b000111) || (opcode == 6'b001000);
    is_halt = (opcode == 6'b111111);
  end

  // Sequencer state, PC, instruction register and sticky illegal flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      pc_q      <= RST_PC;
      ir_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (imem_valid) begin
            ir_q    <= imem_data;
            pc_q    <= pc_d;
            state_q <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (is_ldi)               state_q <= S_WB;
          else if (is_exec)         state_q <= S_EXEC;
          else if (is_ld || is_st)  state_q <= S_MEM;
          else if (is_halt)         state_q <= S_HALT;
          else begin
            state_q   <= S_HALT;
            illegal_q <= 1'b1;
          end
        end
        S_EXEC:  state_q <= S_WB;
        S_MEM: begin
          if (dmem_ready) state_q <= is_ld ? S_WB : S_FETCH;
        end
        S_WB:    state_q <= is_dual ? S_WB2 : S_FETCH;
        S_WB2:   state_q <= S_FETCH;
        S_HALT:  state_q <= S_HALT;
        default: state_q <= S_FETCH;
      endcase
    end
  end

  // Moore strobes: a function of the current state and latched opcode only.
  always_comb begin
    imem_req = (state_q == S_FETCH);
    alu_en   = (state_q == S_EXEC);
    dmem_re  = (state_q == S_MEM) && is_ld;
    dmem_we  = (state_q == S_MEM) && is_st;
    rf_we    = (state_q == S_WB) || (state_q == S_WB2);
    rf_dsel  = (state_q == S_WB2);
    halted   = (state_q == S_HALT);
    rf_wsel  = 2'd0;
    if (state_q == S_WB) begin
      if (is_ldi)      rf_wsel = 2'd0;
      else if (is_mov) rf_wsel = 2'd1;
      else if (is_ld)  rf_wsel = 2'd2;
      else             rf_wsel = 2'd3;
    end else if (state_q == S_WB2) begin
      rf_wsel = 2'd3;
    end
  end

  assign pc      = pc_q;
  assign ir      = ir_q;
  assign illegal = illegal_q;

endmodule
